// File: rtl/serial_frame_ctrl_pkg.sv
// rtl/serial_frame_ctrl_pkg.sv - shared types and constants for the serial frame controller
package serial_frame_ctrl_pkg;

  localparam int PORT_W    = 2;
  localparam int LINE_W    = 2;
  localparam int LEN_W_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PORT,
    S_LINE,
    S_LEN,
    S_PAYLOAD,
    S_DONE
  } state_t;

  localparam logic [3:0] PORT_ONEHOT [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

endpackage

// File: rtl/port_onehot_dec.sv
// rtl/port_onehot_dec.sv - combinational 2-bit port field to one-hot destination decode
module port_onehot_dec
  import serial_frame_ctrl_pkg::*;
(
  input  logic [PORT_W-1:0] i_port,
  output logic [3:0]        o_onehot
);

  assign o_onehot = PORT_ONEHOT[i_port];

endmodule

// File: rtl/serial_frame_ctrl.sv
// rtl/serial_frame_ctrl.sv - serial frame parser: start bit, port, line, length, payload
// Payload bits leave through a two-register pipeline so serOut/valid/P_select move together.
module serial_frame_ctrl
  import serial_frame_ctrl_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serIn,
  output logic       serOut,
  output logic [3:0] P_select,
  output logic [1:0] L_select,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_cnt;
  logic [PORT_W-1:0]  r_port;
  logic [LINE_W-1:0]  r_line;
  logic [LEN_W-1:0]   r_len;
  logic               r_s1_v;
  logic               r_s1_bit;
  logic               r_s1_last;
  logic               r_last;

  logic [LEN_W-1:0]   w_len_val;
  logic               w_port_last;
  logic               w_line_last;
  logic               w_len_last;
  logic               w_pay_last;
  logic               w_pay_sample;
  logic               w_len_zero_end;
  logic [3:0]         w_onehot;

  assign w_len_val   = {r_len[LEN_W-2:0], serIn};
  assign w_port_last = (r_state == S_PORT)    && (r_cnt == LEN_W'(PORT_W - 1));
  assign w_line_last = (r_state == S_LINE)    && (r_cnt == LEN_W'(LINE_W - 1));
  assign w_len_last  = (r_state == S_LEN)     && (r_cnt == LEN_W'(LEN_W - 1));
  assign w_pay_last  = (r_state == S_PAYLOAD) && (r_cnt == LEN_W'(1));

  port_onehot_dec u_dec (
    .i_port   (r_port),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (!serIn)      w_next = S_PORT;
      S_PORT:    if (w_port_last) w_next = S_LINE;
      S_LINE:    if (w_line_last) w_next = S_LEN;
      S_LEN:     if (w_len_last)  w_next = (w_len_val != '0) ? S_PAYLOAD : S_DONE;
      S_PAYLOAD: if (w_pay_last)  w_next = S_DONE;
      S_DONE:                     w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = (r_state != S_IDLE);
    w_pay_sample   = (r_state == S_PAYLOAD);
    w_len_zero_end = w_len_last && (w_len_val == '0);
  end

  // One counter serves every state: counts up through header fields, counts down the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_port   <= '0;
      r_line   <= '0;
      r_len    <= '0;
      L_select <= '0;
    end else begin
      if (r_state != w_next)
        r_cnt <= (w_next == S_PAYLOAD) ? w_len_val : '0;
      else if (r_state == S_PAYLOAD)
        r_cnt <= r_cnt - LEN_W'(1);
      else if (r_state inside {S_PORT, S_LINE, S_LEN})
        r_cnt <= r_cnt + LEN_W'(1);

      if (r_state == S_PORT) r_port <= {r_port[PORT_W-2:0], serIn};
      if (r_state == S_LINE) r_line <= {r_line[LINE_W-2:0], serIn};
      if (r_state == S_LEN)  r_len  <= w_len_val;
      if (w_line_last)       L_select <= {r_line[LINE_W-2:0], serIn};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_bit  <= 1'b0;
      r_s1_last <= 1'b0;
      r_last    <= 1'b0;
      valid     <= 1'b0;
      serOut    <= 1'b0;
      P_select  <= '0;
      done      <= 1'b0;
    end else begin
      r_s1_v    <= w_pay_sample;
      r_s1_bit  <= serIn & w_pay_sample;
      r_s1_last <= w_pay_last;
      valid     <= r_s1_v;
      serOut    <= r_s1_v & r_s1_bit;
      P_select  <= r_s1_v ? w_onehot : 4'b0000;
      r_last    <= r_s1_v & r_s1_last;
      done      <= r_last | w_len_zero_end;
    end
  end

endmodule
